// File: rtl/reset_seq_gen_if.sv
// Reset-sequencer handshake bundle: software request/ack plus sequenced reset and status outputs.
interface reset_seq_gen_if #(
    parameter int unsigned NUM_OUT = 4
);
    logic               req_i;
    logic               req_ack_o;
    logic [NUM_OUT-1:0] rst_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output req_i,
        input  req_ack_o, rst_o, busy_o, done_o
    );

    modport slave (
        input  req_i,
        output req_ack_o, rst_o, busy_o, done_o
    );
endinterface

// File: rtl/reset_seq_gen.sv
// Reset sequence generator: assert all outputs, hold, then release one per step in index order.
// Optional watchdog auto-request enabled by defining RESET_SEQ_GEN_WDT_EN.
module reset_seq_gen #(
    parameter int unsigned NUM_OUT       = 4,
    parameter int unsigned HOLD_CYC      = 16,
    parameter int unsigned STEP_CYC      = 8,
    parameter logic        O_RESET_LEVEL = 1'b0
`ifdef RESET_SEQ_GEN_WDT_EN
    ,
    parameter int unsigned WDT_CYC       = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef RESET_SEQ_GEN_WDT_EN
    input  logic              wdt_kick_i,
    output logic              wdt_fired_o,
`endif
    reset_seq_gen_if.slave    bus
);
    localparam int unsigned CNT_MAX = (HOLD_CYC > STEP_CYC) ? HOLD_CYC : STEP_CYC;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] ALL_ASSERTED = {NUM_OUT{O_RESET_LEVEL}};

    typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_IDLE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_OUT-1:0] rst_q, rst_d;
    logic               ack_q, ack_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               req;

`ifdef RESET_SEQ_GEN_WDT_EN
    localparam int unsigned WW = (WDT_CYC > 1) ? $clog2(WDT_CYC) : 1;
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYC - 1);

    logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic          wdt_fired_q, wdt_fired_d;
    logic          wdt_req;

    assign wdt_req = (state_q == S_IDLE) && !wdt_kick_i && (wdt_cnt_q == WDT_LAST);
    assign req     = bus.req_i | wdt_req;

    always_comb begin
        wdt_cnt_d   = '0;
        wdt_fired_d = wdt_fired_q | wdt_req;
        if (state_q == S_IDLE && !wdt_kick_i && !wdt_req)
            wdt_cnt_d = wdt_cnt_q + WW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt_q   <= '0;
            wdt_fired_q <= 1'b0;
        end else begin
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_fired_q <= wdt_fired_d;
        end
    end

    assign wdt_fired_o = wdt_fired_q;
`else
    assign req = bus.req_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            S_HOLD: begin
                // A request here only restarts the hold window; no ack.
                if (req) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    rst_d[0] = ~O_RESET_LEVEL;
                    cnt_d    = '0;
                    if (NUM_OUT == 1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d   = IW'(1);
                        state_d = S_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RELEASE, S_IDLE: begin
                if (req) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = ALL_ASSERTED;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                end else if (state_q == S_RELEASE) begin
                    if (cnt_q == STEP_LAST) begin
                        rst_d[idx_q] = ~O_RESET_LEVEL;
                        cnt_d        = '0;
                        idx_d        = idx_q + IW'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= ALL_ASSERTED;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.rst_o     = rst_q;
    assign bus.req_ack_o = ack_q;
    assign bus.done_o    = done_q;
    assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed bench for reset_seq_gen with defaults (NUM_OUT=4, HOLD=16, STEP=8, active-low outputs).
module tb_reset_seq_gen;
    logic clk;
    logic rst_n;
    int unsigned errors = 0;
    int unsigned checks = 0;

    reset_seq_gen_if #(.NUM_OUT(4)) bus ();

`ifdef RESET_SEQ_GEN_WDT_EN
    logic wdt_kick;
    logic wdt_fired;
    reset_seq_gen #(.NUM_OUT(4), .HOLD_CYC(16), .STEP_CYC(8), .O_RESET_LEVEL(1'b0), .WDT_CYC(32)) dut (
        .clk(clk), .rst_n(rst_n), .wdt_kick_i(wdt_kick), .wdt_fired_o(wdt_fired), .bus(bus));
`else
    reset_seq_gen #(.NUM_OUT(4), .HOLD_CYC(16), .STEP_CYC(8), .O_RESET_LEVEL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        bus.req_i = 1'b0;
`ifdef RESET_SEQ_GEN_WDT_EN
        wdt_kick = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("por_rst", 16'(bus.rst_o), 16'h0);
        chk("por_busy", 16'(bus.busy_o), 16'h1);
        chk("por_ack", 16'(bus.req_ack_o), 16'h0);
        chk("por_done", 16'(bus.done_o), 16'h0);
        step(2);
        @(negedge clk) rst_n = 1'b1;

        // Power-on sequence: releases at edges 16/24/32/40.
        step(15); chk("seq_e15", 16'(bus.rst_o), 16'h0);
        step(1);  chk("seq_e16", 16'(bus.rst_o), 16'h1);
                  chk("seq_busy16", 16'(bus.busy_o), 16'h1);
        step(7);  chk("seq_e23", 16'(bus.rst_o), 16'h1);
        step(1);  chk("seq_e24", 16'(bus.rst_o), 16'h3);
        step(8);  chk("seq_e32", 16'(bus.rst_o), 16'h7);
        step(7);  chk("seq_e39", 16'(bus.rst_o), 16'h7);
                  chk("seq_done39", 16'(bus.done_o), 16'h0);
        step(1);  chk("seq_e40", 16'(bus.rst_o), 16'hF);
                  chk("seq_done40", 16'(bus.done_o), 16'h1);
                  chk("seq_busy40", 16'(bus.busy_o), 16'h0);
        step(1);  chk("seq_done41", 16'(bus.done_o), 16'h0);
                  chk("seq_busy41", 16'(bus.busy_o), 16'h0);
        step(5);  chk("idle_rst", 16'(bus.rst_o), 16'hF);

        // One-cycle request in IDLE.
        bus.req_i = 1'b1;
        step(1);  chk("req_rst", 16'(bus.rst_o), 16'h0);
                  chk("req_ack", 16'(bus.req_ack_o), 16'h1);
                  chk("req_busy", 16'(bus.busy_o), 16'h1);
        bus.req_i = 1'b0;
        step(1);  chk("req_ack_gone", 16'(bus.req_ack_o), 16'h0);
        step(14); chk("req_e15", 16'(bus.rst_o), 16'h0);
        step(1);  chk("req_e16", 16'(bus.rst_o), 16'h1);

        // Request collides with release of rst_o[2] at relative edge 32.
        step(8);  chk("col_e24", 16'(bus.rst_o), 16'h3);
        step(7);  chk("col_e31", 16'(bus.rst_o), 16'h3);
        bus.req_i = 1'b1;
        step(1);  chk("col_rst", 16'(bus.rst_o), 16'h0);
                  chk("col_ack", 16'(bus.req_ack_o), 16'h1);

        // Keep request high for 10 cycles total; HOLD must not ack.
        for (int unsigned i = 0; i < 9; i++) begin
            step(1);
            chk("hold_ack", 16'(bus.req_ack_o), 16'h0);
            chk("hold_rst", 16'(bus.rst_o), 16'h0);
        end
        bus.req_i = 1'b0;
        step(15); chk("hold_e15", 16'(bus.rst_o), 16'h0);
        step(1);  chk("hold_e16", 16'(bus.rst_o), 16'h1);
                  chk("hold_ack16", 16'(bus.req_ack_o), 16'h0);

        // Asynchronous reset between edges.
        step(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", 16'(bus.rst_o), 16'h0);
        chk("async_busy", 16'(bus.busy_o), 16'h1);
        @(negedge clk) rst_n = 1'b1;
        step(40); chk("re_e40", 16'(bus.rst_o), 16'hF);
                  chk("re_done", 16'(bus.done_o), 16'h1);

`ifdef RESET_SEQ_GEN_WDT_EN
        chk("wdt_init", 16'(wdt_fired), 16'h0);
        for (int unsigned k = 0; k < 3; k++) begin
            step(19);
            wdt_kick = 1'b1;
            step(1);
            wdt_kick = 1'b0;
            chk("wdt_kick_rst", 16'(bus.rst_o), 16'hF);
            chk("wdt_kick_fired", 16'(wdt_fired), 16'h0);
        end
        step(31); chk("wdt_e31_rst", 16'(bus.rst_o), 16'hF);
                  chk("wdt_e31_ack", 16'(bus.req_ack_o), 16'h0);
        step(1);  chk("wdt_e32_rst", 16'(bus.rst_o), 16'h0);
                  chk("wdt_e32_ack", 16'(bus.req_ack_o), 16'h1);
                  chk("wdt_e32_fired", 16'(wdt_fired), 16'h1);
        step(40); chk("wdt_seq_rst", 16'(bus.rst_o), 16'hF);
                  chk("wdt_sticky", 16'(wdt_fired), 16'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reset_seq_gen.md
# reset_seq_gen

Reset sequence generator that drives the design's reset tree. It asserts `NUM_OUT` reset outputs together after power-on reset or a synchronous software request. It holds them for a guaranteed minimum width, then releases them one at a time in index order with a fixed gap. Outputs feed per-domain synchronizers downstream, and request/acknowledge plus busy/done give software and other blocks a handshake for reset progress.

## Interface
- `NUM_OUT`, 4: number of sequenced reset outputs; legal range 1..16.
- `HOLD_CYC`, 16: minimum assertion width in `clk` cycles; legal value ≥2.
- `STEP_CYC`, 8: cycles between consecutive output releases; legal value ≥1.
- `O_RESET_LEVEL`, 1'b0: asserted level of `rst_o`.
- `clk`  input  1  single clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req_i`  input  1  synchronous, level-sensitive software reset request.
- `req_ack_o`  output  1  one-cycle pulse when a request is accepted.
- `rst_o`  output  `NUM_OUT`  sequenced reset outputs, registered.
- `busy_o`  output  1  high while any `rst_o` bit is asserted.
- `done_o`  output  1  one-cycle pulse when the last output releases.

## Operation
- FSM states: HOLD, RELEASE, IDLE. A single counter `cnt` is sized to `$clog2(max(HOLD_CYC,STEP_CYC))`, plus an index `idx` over `NUM_OUT`.
- When `rst_n`=0:
  - The FSM goes to HOLD with `cnt`=0 and `idx`=0.
  - All `rst_o` bits are driven to `O_RESET_LEVEL` immediately, without waiting for a clock edge.
  - `busy_o`=1, `req_ack_o`=0, `done_o`=0.
- **HOLD:**
  - `cnt` increments each edge.
  - If `req_i`=1, `cnt` clears to 0 instead, and no ack is issued.
  - At the edge where `cnt`==`HOLD_CYC`-1 and `req_i`=0: release `rst_o[0]`, clear `cnt`, set `idx`=1, go to RELEASE.
  - If `NUM_OUT`=1, go directly to IDLE instead and pulse `done_o`.
- **RELEASE:**
  - `cnt` increments each edge.
  - At the edge where `cnt`==`STEP_CYC`-1: release `rst_o[idx]`, clear `cnt`, increment `idx`.
  - After releasing `rst_o[NUM_OUT-1]`, go to IDLE, pulse `done_o`, and drop `busy_o`.
- **IDLE:** all outputs are released; `cnt` is frozen.
- **Request accepted:** `req_i`=1 sampled in IDLE or RELEASE. At that edge:
  - all `rst_o` bits re-assert;
  - `req_ack_o` pulses;
  - `busy_o`=1;
  - the FSM enters HOLD with `cnt`=0 and `idx`=0.
- **Simultaneous events:**
  - A request in RELEASE overrides a release due on the same edge; no bit releases on that edge.
  - A request on the release edge in HOLD keeps HOLD.
- Releases are monotonic: a lower index never releases later than a higher one.

## Timing
- Edge 1 is the first `clk` rise after `rst_n` deassertion or after request acceptance.
- The bullets below assume `req_i`=0 after entry.
- `rst_o[0]` releases at edge `HOLD_CYC`.
- `rst_o[k]` releases at edge `HOLD_CYC`+k·`STEP_CYC`.
- `done_o` is high for one cycle after edge `HOLD_CYC`+(`NUM_OUT`-1)·`STEP_CYC`, and `busy_o` falls at the same edge.
- Holding `req_i` high extends HOLD. The first release occurs `HOLD_CYC` edges after the first edge with `req_i`=0 is sampled.
- `req_ack_o` latency is 0 cycles: it registers on the accepting edge.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Configuration
- Macro `RESET_SEQ_GEN_WDT_EN` adds a built-in watchdog:
  - parameter `WDT_CYC` (default 1024);
  - input `wdt_kick_i`;
  - output `wdt_fired_o`.
- Watchdog counter behaviour:
  - counts only in IDLE;
  - is cleared by `wdt_kick_i`=1;
  - is cleared and frozen outside IDLE.
- When the counter reaches `WDT_CYC`-1 without a kick:
  - an internal request is generated, identical to `req_i` including the `req_ack_o` pulse;
  - `wdt_fired_o` sets and stays set until `rst_n`.
- Without the macro, these ports and this logic do not exist, and behaviour matches the sections above.

## Test plan
All scenarios use defaults unless stated.
- `rst_n` low mid-sequence, asserted asynchronously between edges -> `rst_o`=4'b0000 before the next edge, `busy_o`=1.
- `rst_n` release, `req_i`=0 -> `rst_o` bits release at edges 16/24/32/40, then `done_o` pulses once and `busy_o` falls at edge 40.
- `req_i` one-cycle pulse in IDLE -> `req_ack_o` pulses, all `rst_o` re-assert next cycle, `rst_o[0]` releases 16 edges later.
- `req_i` held 10 cycles in HOLD -> no ack, first release 16 edges after `req_i` falls.
- `req_i` on the same edge `rst_o[2]` is due -> `rst_o[2]` stays asserted, `rst_o[1:0]` re-assert, ack pulses.
- With `RESET_SEQ_GEN_WDT_EN`, `WDT_CYC`=32, no kick in IDLE -> internal request at the 32nd IDLE edge, `wdt_fired_o`=1 sticky; kicking every 20 cycles prevents the request.
